// File: rtl/adc16dv160_input_common.sv
// Shared constants and helpers for the adc16dv160 input register block.
package adc16dv160_input_common;

   localparam int unsigned DATA_BITS = 32;
   localparam int unsigned STRB_BITS = DATA_BITS / 8;

   // Register offsets within the decoded address window
   localparam logic [DATA_BITS-1:0] AXI_ADDR_CR    = 32'h0000_0000;
   localparam logic [DATA_BITS-1:0] AXI_ADDR_SR    = 32'h0000_0004;
   localparam logic [DATA_BITS-1:0] AXI_ADDR_DSIZE = 32'h0000_0008;

   // Field masks
   localparam logic [DATA_BITS-1:0] _CR_TEST  = 32'h0000_0001;
   localparam logic [DATA_BITS-1:0] _CR_START = 32'h0000_0002;
   localparam logic [DATA_BITS-1:0] _SR_PC    = 32'h0000_0001;

   // Write response codes
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Merge data into old value, byte by byte, where the strobe is set
   function automatic logic [DATA_BITS-1:0] apply_wstrb(
      input logic [DATA_BITS-1:0] old_val,
      input logic [DATA_BITS-1:0] data,
      input logic [STRB_BITS-1:0] strb
   );
      logic [DATA_BITS-1:0] merged;
      merged = old_val;
      for (int i = 0; i < int'(STRB_BITS); i++) begin
         if (strb[i]) merged[8*i +: 8] = data[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/adc16dv160_input_axi_write.sv
// AXI4-Lite write channel for the adc16dv160 input registers: accepts
// AW/W in either order, commits to CR/SR/DSIZE and returns a B response.
module adc16dv160_input_axi_write
   import adc16dv160_input_common::*;
#(
   parameter int unsigned   ADDR_BITS   = 8,
   parameter logic [31:0]   DSIZE_RESET = 32'h0000_1000
) (
   input  logic        ACLK,
   input  logic        ARESETN,
   input  logic [31:0] AWADDR,
   input  logic        AWVALID,
   output logic        AWREADY,
   input  logic [31:0] WDATA,
   input  logic [3:0]  WSTRB,
   input  logic        WVALID,
   output logic        WREADY,
   output logic [1:0]  BRESP,
   output logic        BVALID,
   input  logic        BREADY,
   output logic        cr_test,
   output logic        cr_start,
   output logic        sr_pc_clr,
   output logic [31:0] dsize
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_W,
      S_WAIT_A,
      S_WRITE,
      S_RESP
   } state_t;

   state_t                 state_q, state_d;
   logic [ADDR_BITS-1:0]   addr_q;
   logic [DATA_BITS-1:0]   data_q;
   logic [STRB_BITS-1:0]   strb_q;
   logic                   aw_ready_s, w_ready_s;
   logic                   aw_hs, w_hs;
   logic                   is_cr, is_sr, is_dsize;
   logic                   unused_addr_hi;

   // Ready/valid are Moore decodes of state, held low while in reset
   assign aw_ready_s = (state_q == S_IDLE) || (state_q == S_WAIT_A);
   assign w_ready_s  = (state_q == S_IDLE) || (state_q == S_WAIT_W);
   assign AWREADY    = ARESETN & aw_ready_s;
   assign WREADY     = ARESETN & w_ready_s;
   assign BVALID     = ARESETN & (state_q == S_RESP);
   assign aw_hs      = AWVALID & aw_ready_s;
   assign w_hs       = WVALID & w_ready_s;

   // Only the low address bits are decoded
   assign unused_addr_hi = ^AWADDR[31:ADDR_BITS];
   assign is_cr    = (addr_q == ADDR_BITS'(AXI_ADDR_CR));
   assign is_sr    = (addr_q == ADDR_BITS'(AXI_ADDR_SR));
   assign is_dsize = (addr_q == ADDR_BITS'(AXI_ADDR_DSIZE));

   // State register
   always_ff @(posedge ACLK) begin
      if (!ARESETN) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (aw_hs && w_hs) state_d = S_WRITE;
            else if (aw_hs)    state_d = S_WAIT_W;
            else if (w_hs)     state_d = S_WAIT_A;
         end
         S_WAIT_W: if (w_hs)   state_d = S_WRITE;
         S_WAIT_A: if (aw_hs)  state_d = S_WRITE;
         S_WRITE:              state_d = S_RESP;
         S_RESP:   if (BREADY) state_d = S_IDLE;
         default:              state_d = S_IDLE;
      endcase
   end

   // Capture address and data on their respective handshakes
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         addr_q <= '0;
         data_q <= '0;
         strb_q <= '0;
      end else begin
         if (aw_hs) addr_q <= AWADDR[ADDR_BITS-1:0];
         if (w_hs) begin
            data_q <= WDATA;
            strb_q <= WSTRB;
         end
      end
   end

   // Commit the latched write to the registers and form the response
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         cr_test   <= 1'b0;
         cr_start  <= 1'b0;
         sr_pc_clr <= 1'b0;
         dsize     <= DSIZE_RESET;
         BRESP     <= RESP_OKAY;
      end else begin
         cr_start  <= 1'b0;
         sr_pc_clr <= 1'b0;
         if (state_q == S_WRITE) begin
            BRESP <= (is_cr || is_sr || is_dsize) ? RESP_OKAY : RESP_SLVERR;
            if (is_cr && strb_q[0]) begin
               cr_test  <= |(data_q & _CR_TEST);
               cr_start <= |(data_q & _CR_START);
            end
            if (is_sr && strb_q[0]) sr_pc_clr <= |(data_q & _SR_PC);
            if (is_dsize) dsize <= apply_wstrb(dsize, data_q, strb_q);
         end
      end
   end

endmodule

// File: tb/tb_adc16dv160_input_axi_write.sv
// Randomized self-checking bench for adc16dv160_input_axi_write.
module tb_adc16dv160_input_axi_write;

   logic        ACLK = 1'b0;
   logic        ARESETN;
   logic [31:0] AWADDR;
   logic        AWVALID;
   logic        AWREADY;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        WVALID;
   logic        WREADY;
   logic [1:0]  BRESP;
   logic        BVALID;
   logic        BREADY;
   logic        cr_test;
   logic        cr_start;
   logic        sr_pc_clr;
   logic [31:0] dsize;

   int total = 0;
   int bad   = 0;

   // Reference state of the register block
   logic        m_cr_test = 1'b0;
   logic [31:0] m_dsize   = 32'h0000_1000;

   adc16dv160_input_axi_write dut (
      .ACLK      (ACLK),
      .ARESETN   (ARESETN),
      .AWADDR    (AWADDR),
      .AWVALID   (AWVALID),
      .AWREADY   (AWREADY),
      .WDATA     (WDATA),
      .WSTRB     (WSTRB),
      .WVALID    (WVALID),
      .WREADY    (WREADY),
      .BRESP     (BRESP),
      .BVALID    (BVALID),
      .BREADY    (BREADY),
      .cr_test   (cr_test),
      .cr_start  (cr_start),
      .sr_pc_clr (sr_pc_clr),
      .dsize     (dsize)
   );

   always #5 ACLK = ~ACLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Register-map behaviour: returns expected response and pulse counts
   task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, output logic [1:0] resp,
                              output int e_start, output int e_pc);
      logic [7:0] off;
      off = addr[7:0];
      resp = 2'b00;
      e_start = 0;
      e_pc = 0;
      case (off)
         8'h00: if (strb[0]) begin
            m_cr_test = data[0];
            e_start = data[1] ? 1 : 0;
         end
         8'h04: if (strb[0] && data[0]) e_pc = 1;
         8'h08: for (int b = 0; b < 4; b++)
            if (strb[b]) m_dsize[8*b +: 8] = data[8*b +: 8];
         default: resp = 2'b10;
      endcase
   endtask

   // One write transaction with per-channel delays and a B backpressure delay
   task automatic xact(input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input int aw_dly, input int w_dly,
                       input int b_dly, input string name);
      logic [1:0] e_resp, r_first;
      int e_start, e_pc;
      int hs_c = -1, bv_c = -1, st_c = -1, pc_c = -1;
      int n_start = 0, n_pc = 0;
      bit aw_done = 0, w_done = 0, b_done = 0;
      model_write(addr, data, strb, e_resp, e_start, e_pc);
      r_first = 2'b00;
      for (int c = 0; c < 60 && !b_done; c++) begin
         @(posedge ACLK); #1;
         AWADDR  = addr;
         WDATA   = data;
         WSTRB   = strb;
         AWVALID = !aw_done && (c >= aw_dly);
         WVALID  = !w_done && (c >= w_dly);
         BREADY  = (b_dly == 0) || (bv_c >= 0 && (c - bv_c) >= b_dly);
         @(negedge ACLK);
         if (cr_start)  begin n_start++; st_c = c; end
         if (sr_pc_clr) begin n_pc++;    pc_c = c; end
         if (BVALID) begin
            if (bv_c < 0) begin
               bv_c = c;
               r_first = BRESP;
            end else begin
               total++;
               if (BRESP !== r_first) begin
                  bad++;
                  $display("FAIL %s bresp_stable: got %b want %b", name, BRESP, r_first);
               end
            end
            total++;
            if (AWREADY !== 1'b0 || WREADY !== 1'b0) begin
               bad++;
               $display("FAIL %s ready_in_resp: got aw=%b w=%b want 0 0", name, AWREADY, WREADY);
            end
            if (BREADY) b_done = 1;
         end
         if (AWVALID && AWREADY) aw_done = 1;
         if (WVALID && WREADY)   w_done = 1;
         if (aw_done && w_done && hs_c < 0) hs_c = c;
      end
      AWVALID = 1'b0;
      WVALID  = 1'b0;
      total++;
      if (!b_done) begin
         bad++;
         $display("FAIL %s timeout: got no B handshake want one within 60 cycles", name);
      end
      total++;
      if (bv_c - hs_c != 2) begin
         bad++;
         $display("FAIL %s latency: got %0d want 2", name, bv_c - hs_c);
      end
      total++;
      if (r_first !== e_resp) begin
         bad++;
         $display("FAIL %s bresp: got %b want %b", name, r_first, e_resp);
      end
      total++;
      if (n_start != e_start || (n_start > 0 && st_c != bv_c)) begin
         bad++;
         $display("FAIL %s cr_start: got %0d pulses at %0d want %0d at %0d", name, n_start, st_c, e_start, bv_c);
      end
      total++;
      if (n_pc != e_pc || (n_pc > 0 && pc_c != bv_c)) begin
         bad++;
         $display("FAIL %s sr_pc_clr: got %0d pulses at %0d want %0d at %0d", name, n_pc, pc_c, e_pc, bv_c);
      end
      total++;
      if (dsize !== m_dsize) begin
         bad++;
         $display("FAIL %s dsize: got %h want %h", name, dsize, m_dsize);
      end
      total++;
      if (cr_test !== m_cr_test) begin
         bad++;
         $display("FAIL %s cr_test: got %b want %b", name, cr_test, m_cr_test);
      end
   endtask

   task automatic test_reset();
      ARESETN = 1'b0;
      AWVALID = 1'b0;
      WVALID  = 1'b0;
      BREADY  = 1'b0;
      AWADDR  = '0;
      WDATA   = '0;
      WSTRB   = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge ACLK);
         total++;
         if (AWREADY !== 1'b0 || WREADY !== 1'b0 || BVALID !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready: got aw=%b w=%b b=%b want 0 0 0", AWREADY, WREADY, BVALID);
         end
      end
      @(posedge ACLK); #1;
      ARESETN = 1'b1;
      @(negedge ACLK);
      total++;
      if (AWREADY !== 1'b1 || WREADY !== 1'b1 || BVALID !== 1'b0) begin
         bad++;
         $display("FAIL reset_idle: got aw=%b w=%b b=%b want 1 1 0", AWREADY, WREADY, BVALID);
      end
      total++;
      if (dsize !== 32'h0000_1000 || cr_test !== 1'b0 || cr_start !== 1'b0 ||
          sr_pc_clr !== 1'b0 || BRESP !== 2'b00) begin
         bad++;
         $display("FAIL reset_regs: got dsize=%h test=%b start=%b pc=%b bresp=%b want 00001000 0 0 0 00",
                  dsize, cr_test, cr_start, sr_pc_clr, BRESP);
      end
   endtask

   task automatic test_simultaneous();
      xact(32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, "simul_dsize");
   endtask

   task automatic test_w_before_a();
      xact(32'h0000_0008, 32'h0000_1000, 4'hF, 0, 0, 0, "wba_preset");
      xact(32'h0000_0008, 32'h0000_00AA, 4'b0001, 2, 0, 0, "wba_dsize");
      total++;
      if (dsize !== 32'h0000_10AA) begin
         bad++;
         $display("FAIL wba_value: got %h want 000010aa", dsize);
      end
      xact(32'h0000_0000, 32'h0000_0001, 4'h1, 0, 3, 1, "awa_cr");
   endtask

   task automatic test_cr_sr();
      xact(32'h0000_0000, 32'h0000_0003, 4'hF, 0, 0, 0, "cr_start_test");
      xact(32'h0000_0004, 32'h0000_0001, 4'hF, 0, 0, 0, "sr_pc");
      total++;
      if (cr_test !== 1'b1) begin
         bad++;
         $display("FAIL cr_test_held: got %b want 1", cr_test);
      end
      xact(32'h0000_0000, 32'h0000_0000, 4'h0, 0, 0, 0, "cr_nostrb");
      xact(32'h0000_0004, 32'h0000_0000, 4'hF, 0, 0, 0, "sr_zero");
      xact(32'h0000_0000, 32'h0000_0000, 4'hF, 0, 0, 0, "cr_clear");
   endtask

   task automatic test_slverr();
      xact(32'h0000_000C, 32'hFFFF_FFFF, 4'hF, 0, 0, 4, "slverr");
      xact(32'hABCD_0108, 32'h1234_5678, 4'hF, 1, 0, 0, "hi_bits_ignored");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++)
         xact(32'h0000_0008, 32'h1111_1111 * (i + 1), 4'hF, 0, 0, 0, "b2b");
   endtask

   task automatic test_random();
      logic [31:0] hi, data, addr;
      logic [7:0]  off;
      logic [3:0]  strb;
      for (int i = 0; i < 40; i++) begin
         hi = $urandom();
         data = $urandom();
         strb = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 4))
            0: off = 8'h00;
            1: off = 8'h04;
            2: off = 8'h08;
            3: off = 8'h0C;
            default: off = 8'($urandom_range(0, 255));
         endcase
         addr = {hi[31:8], off};
         xact(addr, data, strb, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), "random");
      end
   endtask

   task automatic test_reset_in_resp();
      int guard;
      @(posedge ACLK); #1;
      AWADDR  = 32'h0000_0008;
      WDATA   = 32'h5A5A_5A5A;
      WSTRB   = 4'hF;
      AWVALID = 1'b1;
      WVALID  = 1'b1;
      BREADY  = 1'b0;
      @(posedge ACLK); #1;
      AWVALID = 1'b0;
      WVALID  = 1'b0;
      guard = 0;
      @(negedge ACLK);
      while (!BVALID && guard < 10) begin
         @(negedge ACLK);
         guard++;
      end
      total++;
      if (BVALID !== 1'b1) begin
         bad++;
         $display("FAIL rst_resp_reach: got bvalid=%b want 1", BVALID);
      end
      @(posedge ACLK); #1;
      ARESETN = 1'b0;
      @(negedge ACLK);
      total++;
      if (BVALID !== 1'b0) begin
         bad++;
         $display("FAIL rst_resp_bvalid_comb: got %b want 0", BVALID);
      end
      @(negedge ACLK);
      m_dsize = 32'h0000_1000;
      m_cr_test = 1'b0;
      total++;
      if (dsize !== m_dsize || cr_test !== m_cr_test || BVALID !== 1'b0) begin
         bad++;
         $display("FAIL rst_resp_regs: got dsize=%h test=%b bvalid=%b want %h %b 0",
                  dsize, cr_test, BVALID, m_dsize, m_cr_test);
      end
      @(posedge ACLK); #1;
      ARESETN = 1'b1;
      @(negedge ACLK);
      total++;
      if (AWREADY !== 1'b1 || WREADY !== 1'b1 || BVALID !== 1'b0) begin
         bad++;
         $display("FAIL rst_resp_idle: got aw=%b w=%b b=%b want 1 1 0", AWREADY, WREADY, BVALID);
      end
      xact(32'h0000_0008, 32'h0000_0042, 4'h1, 0, 0, 0, "after_reset");
   endtask

   initial begin
      test_reset();
      test_simultaneous();
      test_w_before_a();
      test_cr_sr();
      test_slverr();
      test_back_to_back();
      test_random();
      test_reset_in_resp();
      @(posedge ACLK); #1;
      BREADY = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
